// File: rtl/cbus_arb_pkg.sv
// Arbiter-local types and limits for cbus_rr_arbiter.
package cbus_arb_pkg;

    localparam int MAX_CH       = 8;
    localparam int ID_W_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cbus_pkg.sv
// Common CBus request/response structs shared by all masters and the memory port.
package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first set req bit scanning upward from base (or from 0 in fixed mode).
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick #(
    parameter int NUM_CH = 2,
    parameter int ID_W   = 3
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [ID_W-1:0]   base,
    input  logic              rr_mode,
    output logic              any,
    output logic [ID_W-1:0]   idx
);

    logic [2*NUM_CH-1:0] dbl;
    int                  start;
    int                  cand;

    always_comb begin
        any   = |req;
        idx   = '0;
        start = rr_mode ? int'(base) : 0;
        cand  = 0;
        // Doubling the vector turns the wrap-around into a plain shift.
        dbl   = {req, req} >> start;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (dbl[k]) begin
                cand = start + k;
                if (cand >= NUM_CH) begin
                    cand = cand - NUM_CH;
                end
                idx = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N-way CBus arbiter: merges per-master requests onto one memory port, grant held for a whole burst.
// Latency: request valid at edge t is visible on oreq from cycle t+1; data/resp paths are combinational.
// Backpressure: non-granted masters see ready=0 and must hold their request; memory ready passes through.
module cbus_rr_arbiter
    import cbus_pkg::*;
    import cbus_arb_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ID_W       = ID_W_DEFAULT,
    parameter int RR_MODE    = 1,
    parameter int TURNAROUND = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  cbus_req_t         ireqs  [NUM_CH],
    output cbus_resp_t        iresps [NUM_CH],
    output cbus_req_t         oreq,
    input  cbus_resp_t        oresp,
    output logic              busy,
    output logic [ID_W-1:0]   grant_id
);

    arb_state_t        state, state_nxt;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt, grant_nxt;
    logic [NUM_CH-1:0] req_vld;
    logic              pick_any;
    logic [ID_W-1:0]   pick_idx;
    logic              done;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_vld
        assign req_vld[i] = ireqs[i].valid;
    end

    rr_pick #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_pick (
        .req     (req_vld),
        .base    (rr_ptr),
        .rr_mode (RR_MODE != 0),
        .any     (pick_any),
        .idx     (pick_idx)
    );

    assign done = (state == BUSY) && oresp.ready && oresp.last;
    assign busy = (state == BUSY);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            rr_ptr   <= rr_ptr_nxt;
        end
    end

    // Arbitration only ever happens from IDLE, so a completion never re-grants in the same cycle.
    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant_id;
        rr_ptr_nxt = rr_ptr;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = BUSY;
                    grant_nxt = pick_idx;
                end
            end
            BUSY: begin
                if (done) begin
                    state_nxt  = (TURNAROUND != 0) ? GAP : IDLE;
                    rr_ptr_nxt = (grant_id == ID_W'(NUM_CH - 1)) ? '0 : grant_id + ID_W'(1);
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        oreq = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            iresps[i] = '0;
        end
        if (state == BUSY) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (grant_id == ID_W'(i)) begin
                    oreq      = ireqs[i];
                    iresps[i] = oresp;
                end
            end
        end
    end

endmodule
